// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined MIPS control unit with hazard stall and mult/div busy interlock.
// Ports:
//   clk, reset       core clock, synchronous active-high reset
//   IR_D             instruction word in the D stage
//   stall            freeze PC/D register and bubble E (combinational)
//   PC_sel_D         next-PC source, ExtOp_D immediate extension (combinational)
//   *_E / *_M / *_W  control bundle registered through the E, M and W stages
//   md_busy          mult/div unit still busy after its start cycle
module ctrl_pipe #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_D,
   output logic        stall,
   output logic [2:0]  PC_sel_D,
   output logic [2:0]  ExtOp_D,
   output logic [2:0]  ALUCtrl_E,
   output logic        ALUB_sel_E,
   output logic [1:0]  md_op_E,
   output logic        md_start_E,
   output logic        mt_hi_E,
   output logic        mt_lo_E,
   output logic        hilo_sel_E,
   output logic        md_busy,
   output logic [4:0]  A3_E,
   output logic [4:0]  A3_M,
   output logic [4:0]  A3_W,
   output logic        MemWrite_M,
   output logic [2:0]  MemtoReg_E,
   output logic [2:0]  MemtoReg_M,
   output logic [2:0]  MemtoReg_W
);
   typedef struct packed {
      logic [2:0] alu;
      logic       alub;
      logic [1:0] md_op;
      logic       md_start;
      logic       mt_hi;
      logic       mt_lo;
      logic       hilo_sel;
      logic [4:0] a3;
      logic       mem_write;
      logic [2:0] mem_to_reg;
   } bundle_t;

   logic [5:0] op, fn;
   logic [4:0] rs, rt, rd;
   logic unused_shamt;
   logic r_type, addu, subu, jr, jalr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
   logic ori, lui, lw, sw, beq, j, jal, md, mf, mt;
   logic rs_read, rt_read;
   logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
   logic stall_rs, stall_rt, stall_md;
   bundle_t dec, e_q;
   logic [4:0] a3_m, a3_w;
   logic [2:0] m2r_m, m2r_w;
   logic mem_write_m;
   logic [CNT_W-1:0] cnt;

   assign op = IR_D[31:26];
   assign rs = IR_D[25:21];
   assign rt = IR_D[20:16];
   assign rd = IR_D[15:11];
   assign fn = IR_D[5:0];
   assign unused_shamt = ^IR_D[10:6];

   assign r_type = op == 6'h00;
   assign addu   = r_type && fn == 6'h21;
   assign subu   = r_type && fn == 6'h23;
   assign jr     = r_type && fn == 6'h08;
   assign jalr   = r_type && fn == 6'h09;
   assign mult   = r_type && fn == 6'h18;
   assign multu  = r_type && fn == 6'h19;
   assign div    = r_type && fn == 6'h1a;
   assign divu   = r_type && fn == 6'h1b;
   assign mfhi   = r_type && fn == 6'h10;
   assign mflo   = r_type && fn == 6'h12;
   assign mthi   = r_type && fn == 6'h11;
   assign mtlo   = r_type && fn == 6'h13;
   assign ori    = op == 6'h0d;
   assign lui    = op == 6'h0f;
   assign lw     = op == 6'h23;
   assign sw     = op == 6'h2b;
   assign beq    = op == 6'h04;
   assign j      = op == 6'h02;
   assign jal    = op == 6'h03;
   assign md     = mult || multu || div || divu;
   assign mf     = mfhi || mflo;
   assign mt     = mthi || mtlo;

   assign PC_sel_D = beq ? 3'd1 : (jr || jalr) ? 3'd2 : (j || jal) ? 3'd3 : 3'd0;
   assign ExtOp_D  = ori ? 3'd1 : lui ? 3'd2 : 3'd0;

   always_comb begin
      dec            = '0;
      dec.alu        = (subu || beq) ? 3'd1 : (ori || lui) ? 3'd2 : 3'd0;
      dec.alub       = ori || lui || lw || sw;
      dec.md_op      = {div || divu, multu || divu};
      dec.md_start   = md;
      dec.mt_hi      = mthi;
      dec.mt_lo      = mtlo;
      dec.hilo_sel   = mflo;
      dec.a3         = (ori || lui || lw) ? rt : (addu || subu || mf || jalr) ? rd : jal ? 5'd31 : 5'd0;
      dec.mem_write  = sw;
      dec.mem_to_reg = lw ? 3'd1 : (jal || jalr) ? 3'd2 : mf ? 3'd3 : 3'd0;
   end

   // Tuse of the D-stage reader; branch/jump-register sources are needed immediately.
   assign rs_read = addu || subu || ori || lw || sw || beq || jr || jalr || md || mt;
   assign rt_read = addu || subu || md || beq || sw;
   assign tuse_rs = (beq || jr || jalr) ? 2'd0 : 2'd1;
   assign tuse_rt = beq ? 2'd0 : sw ? 2'd2 : 2'd1;

   // Tnew follows from the writeback source: DM loads need 2, link writes are ready, the rest need 1.
   assign tnew_e = (e_q.mem_to_reg == 3'd1) ? 2'd2 : (e_q.mem_to_reg == 3'd2) ? 2'd0 : 2'd1;
   assign tnew_m = {1'b0, m2r_m == 3'd1};

   assign stall_rs = rs_read && rs != 5'd0 &&
                     ((rs == e_q.a3 && tnew_e > tuse_rs) || (rs == a3_m && tnew_m > tuse_rs));
   assign stall_rt = rt_read && rt != 5'd0 &&
                     ((rt == e_q.a3 && tnew_e > tuse_rt) || (rt == a3_m && tnew_m > tuse_rt));
   assign stall_md = (md || mf || mt) && (e_q.md_start || md_busy);
   assign stall    = stall_rs || stall_rt || stall_md;

   always_ff @(posedge clk) e_q <= (reset || stall) ? '0 : dec;

   always_ff @(posedge clk) begin
      if (reset) begin
         a3_m        <= '0;
         m2r_m       <= '0;
         mem_write_m <= 1'b0;
         a3_w        <= '0;
         m2r_w       <= '0;
         cnt         <= '0;
      end else begin
         a3_m        <= e_q.a3;
         m2r_m       <= e_q.mem_to_reg;
         mem_write_m <= e_q.mem_write;
         a3_w        <= a3_m;
         m2r_w       <= m2r_m;
         cnt         <= e_q.md_start ? (e_q.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) :
                        (cnt != '0) ? cnt - CNT_W'(1) : cnt;
      end
   end

   assign md_busy    = cnt != '0;
   assign ALUCtrl_E  = e_q.alu;
   assign ALUB_sel_E = e_q.alub;
   assign md_op_E    = e_q.md_op;
   assign md_start_E = e_q.md_start;
   assign mt_hi_E    = e_q.mt_hi;
   assign mt_lo_E    = e_q.mt_lo;
   assign hilo_sel_E = e_q.hilo_sel;
   assign A3_E       = e_q.a3;
   assign MemtoReg_E = e_q.mem_to_reg;
   assign A3_M       = a3_m;
   assign MemtoReg_M = m2r_m;
   assign MemWrite_M = mem_write_m;
   assign A3_W       = a3_w;
   assign MemtoReg_W = m2r_w;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus a randomized run against an instruction-level reference model.
module tb_ctrl_pipe;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] IR_D;
   logic stall, ALUB_sel_E, md_start_E, mt_hi_E, mt_lo_E, hilo_sel_E, md_busy, MemWrite_M;
   logic [2:0] PC_sel_D, ExtOp_D, ALUCtrl_E, MemtoReg_E, MemtoReg_M, MemtoReg_W;
   logic [1:0] md_op_E;
   logic [4:0] A3_E, A3_M, A3_W;
   logic [35:0] regs_v;
   int checks = 0;
   int errors = 0;

   ctrl_pipe dut (
      .clk(clk), .reset(reset), .IR_D(IR_D), .stall(stall), .PC_sel_D(PC_sel_D), .ExtOp_D(ExtOp_D),
      .ALUCtrl_E(ALUCtrl_E), .ALUB_sel_E(ALUB_sel_E), .md_op_E(md_op_E), .md_start_E(md_start_E),
      .mt_hi_E(mt_hi_E), .mt_lo_E(mt_lo_E), .hilo_sel_E(hilo_sel_E), .md_busy(md_busy),
      .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W), .MemWrite_M(MemWrite_M),
      .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .MemtoReg_W(MemtoReg_W)
   );

   always #5 clk = ~clk;

   assign regs_v = {ALUCtrl_E, ALUB_sel_E, md_op_E, md_start_E, mt_hi_E, mt_lo_E, hilo_sel_E,
                    A3_E, A3_M, A3_W, MemWrite_M, MemtoReg_E, MemtoReg_M, MemtoReg_W, md_busy};

   localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_ORI = 3, K_LUI = 4, K_LW = 5, K_SW = 6,
                  K_BEQ = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_JALR = 11, K_MULT = 12, K_MULTU = 13,
                  K_DIV = 14, K_DIVU = 15, K_MFHI = 16, K_MFLO = 17, K_MTHI = 18, K_MTLO = 19;

   function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
      return {6'h00, s, t, d, 5'd0, f};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
      return {o, s, t, imm};
   endfunction

   function automatic int kind(input logic [31:0] ir);
      logic [5:0] o, f;
      o = ir[31:26];
      f = ir[5:0];
      if (o == 6'h00)
         case (f)
            6'h21: return K_ADDU;  6'h23: return K_SUBU;  6'h08: return K_JR;    6'h09: return K_JALR;
            6'h18: return K_MULT;  6'h19: return K_MULTU; 6'h1a: return K_DIV;   6'h1b: return K_DIVU;
            6'h10: return K_MFHI;  6'h12: return K_MFLO;  6'h11: return K_MTHI;  6'h13: return K_MTLO;
            default: return K_NOP;
         endcase
      case (o)
         6'h0d: return K_ORI; 6'h0f: return K_LUI; 6'h23: return K_LW; 6'h2b: return K_SW;
         6'h04: return K_BEQ; 6'h02: return K_J;   6'h03: return K_JAL;
         default: return K_NOP;
      endcase
   endfunction

   function automatic logic is_md(input int k);
      return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU};
   endfunction

   function automatic logic [4:0] f_a3(input logic [31:0] ir);
      int k;
      k = kind(ir);
      if (k inside {K_ORI, K_LUI, K_LW}) return ir[20:16];
      if (k inside {K_ADDU, K_SUBU, K_MFHI, K_MFLO, K_JALR}) return ir[15:11];
      if (k == K_JAL) return 5'd31;
      return 5'd0;
   endfunction

   function automatic logic [2:0] f_alu(input int k);
      return (k inside {K_SUBU, K_BEQ}) ? 3'd1 : (k inside {K_ORI, K_LUI}) ? 3'd2 : 3'd0;
   endfunction

   function automatic logic [1:0] f_mdop(input int k);
      case (k)
         K_MULTU: return 2'd1;
         K_DIV:   return 2'd2;
         K_DIVU:  return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [2:0] f_m2r(input int k);
      if (k == K_LW) return 3'd1;
      if (k inside {K_JAL, K_JALR}) return 3'd2;
      if (k inside {K_MFHI, K_MFLO}) return 3'd3;
      return 3'd0;
   endfunction

   function automatic logic [2:0] f_pcsel(input int k);
      return (k == K_BEQ) ? 3'd1 : (k inside {K_JR, K_JALR}) ? 3'd2 : (k inside {K_J, K_JAL}) ? 3'd3 : 3'd0;
   endfunction

   function automatic logic [2:0] f_ext(input int k);
      return (k == K_ORI) ? 3'd1 : (k == K_LUI) ? 3'd2 : 3'd0;
   endfunction

   function automatic int f_tnew_e(input int k);
      if (k == K_LW) return 2;
      if (k inside {K_ADDU, K_SUBU, K_LUI, K_ORI, K_MFHI, K_MFLO}) return 1;
      return 0;
   endfunction

   // Returns -1 when the source is not read at all.
   function automatic int f_tuse_rs(input int k);
      if (k inside {K_BEQ, K_JR, K_JALR}) return 0;
      if (k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_MTHI, K_MTLO} || is_md(k)) return 1;
      return -1;
   endfunction

   function automatic int f_tuse_rt(input int k);
      if (k == K_BEQ) return 0;
      if (k == K_SW) return 2;
      if (k inside {K_ADDU, K_SUBU} || is_md(k)) return 1;
      return -1;
   endfunction

   function automatic logic src_hazard(input logic [4:0] src, input int tuse, input logic [31:0] ie, input logic [31:0] im);
      int tm;
      tm = (kind(im) == K_LW) ? 1 : 0;
      if (tuse < 0 || src == 5'd0) return 1'b0;
      return (src == f_a3(ie) && f_tnew_e(kind(ie)) > tuse) || (src == f_a3(im) && tm > tuse);
   endfunction

   function automatic logic exp_stall(input logic [31:0] d, input logic [31:0] ie, input logic [31:0] im, input logic busy);
      int kd;
      kd = kind(d);
      if (src_hazard(d[25:21], f_tuse_rs(kd), ie, im)) return 1'b1;
      if (src_hazard(d[20:16], f_tuse_rt(kd), ie, im)) return 1'b1;
      return (is_md(kd) || kd inside {K_MFHI, K_MFLO, K_MTHI, K_MTLO}) && (is_md(kind(ie)) || busy);
   endfunction

   function automatic logic [35:0] exp_regs(input logic [31:0] ie, input logic [31:0] im, input logic [31:0] iw, input logic busy);
      int ke, km, kw;
      ke = kind(ie);
      km = kind(im);
      kw = kind(iw);
      return {f_alu(ke), ke inside {K_ORI, K_LUI, K_LW, K_SW}, f_mdop(ke), is_md(ke), ke == K_MTHI,
              ke == K_MTLO, ke == K_MFLO, f_a3(ie), f_a3(im), f_a3(iw), km == K_SW,
              f_m2r(ke), f_m2r(km), f_m2r(kw), busy};
   endfunction

   function automatic logic [31:0] rand_ir();
      logic [4:0] a, b, c;
      logic [15:0] imm;
      a   = 5'($urandom_range(0, 3));
      b   = 5'($urandom_range(0, 3));
      c   = 5'($urandom_range(0, 3));
      imm = 16'($urandom);
      case ($urandom_range(0, 22))
         0:  return enc_r(a, b, c, 6'h21);
         1:  return enc_r(a, b, c, 6'h23);
         2:  return enc_i(6'h0d, a, b, imm);
         3:  return enc_i(6'h0f, 5'd0, b, imm);
         4:  return enc_i(6'h23, a, b, imm);
         5:  return enc_i(6'h2b, a, b, imm);
         6:  return enc_i(6'h04, a, b, imm);
         7:  return {6'h02, 26'($urandom)};
         8:  return {6'h03, 26'($urandom)};
         9:  return enc_r(a, 5'd0, 5'd0, 6'h08);
         10: return enc_r(a, 5'd0, c, 6'h09);
         11: return enc_r(a, b, 5'd0, 6'h18);
         12: return enc_r(a, b, 5'd0, 6'h19);
         13: return enc_r(a, b, 5'd0, 6'h1a);
         14: return enc_r(a, b, 5'd0, 6'h1b);
         15: return enc_r(5'd0, 5'd0, c, 6'h10);
         16: return enc_r(5'd0, 5'd0, c, 6'h12);
         17: return enc_r(a, 5'd0, 5'd0, 6'h11);
         18: return enc_r(a, 5'd0, 5'd0, 6'h13);
         19: return enc_i(6'h08, a, b, imm);
         20: return 32'h0;
         21: return enc_r(a, b, c, 6'h20);
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      IR_D = 32'h0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      IR_D  = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      IR_D  = enc_r(5'd2, 5'd3, 5'd0, 6'h1a);
      tick();
      IR_D = 32'h0;
      @(negedge clk);
      checks++;
      if ({md_start_E, md_op_E} !== 3'b110) begin
         errors++;
         $display("FAIL reset_div_in_e got %b expected 110", {md_start_E, md_op_E});
      end
      reset = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if ({md_busy, md_start_E} !== 2'b00) begin
         errors++;
         $display("FAIL reset_kills_div got %b expected 00", {md_busy, md_start_E});
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (regs_v !== 36'h0) begin
         errors++;
         $display("FAIL reset_regs got %h expected 0", regs_v);
      end
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({md_busy, A3_E, A3_M, A3_W} !== 16'h0) begin
         errors++;
         $display("FAIL reset_after_release got %h expected 0", {md_busy, A3_E, A3_M, A3_W});
      end
   endtask

   task automatic test_load_use();
      flush();
      IR_D = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
      tick();
      IR_D = enc_r(5'd8, 5'd8, 5'd9, 6'h21);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL load_use_stall got %b expected 1", stall);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({stall, A3_E, A3_M} !== {1'b0, 5'd0, 5'd8}) begin
         errors++;
         $display("FAIL load_use_bubble got stall=%b A3_E=%0d A3_M=%0d expected 0/0/8", stall, A3_E, A3_M);
      end
      tick();
      IR_D = 32'h0;
      @(negedge clk);
      checks++;
      if ({A3_E, A3_M, A3_W, MemtoReg_W} !== {5'd9, 5'd0, 5'd8, 3'd1}) begin
         errors++;
         $display("FAIL load_use_advance got E=%0d M=%0d W=%0d m2r_W=%0d expected 9/0/8/1", A3_E, A3_M, A3_W, MemtoReg_W);
      end
   endtask

   task automatic test_branch();
      int n;
      flush();
      IR_D = enc_i(6'h0d, 5'd0, 5'd5, 16'd1);
      @(negedge clk);
      checks++;
      if (ExtOp_D !== 3'd1) begin
         errors++;
         $display("FAIL ori_extop got %0d expected 1", ExtOp_D);
      end
      tick();
      IR_D = enc_i(6'h04, 5'd5, 5'd0, 16'd4);
      n = 0;
      @(negedge clk);
      while (stall === 1'b1 && n < 20) begin
         n++;
         tick();
         @(negedge clk);
      end
      checks++;
      if (n !== 1 || PC_sel_D !== 3'd1) begin
         errors++;
         $display("FAIL beq_after_ori got stalls=%0d pcsel=%0d expected 1/1", n, PC_sel_D);
      end
      flush();
      IR_D = enc_i(6'h23, 5'd0, 5'd5, 16'd0);
      tick();
      IR_D = enc_i(6'h04, 5'd5, 5'd0, 16'd4);
      n = 0;
      @(negedge clk);
      while (stall === 1'b1 && n < 20) begin
         n++;
         tick();
         @(negedge clk);
      end
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL beq_after_lw got stalls=%0d expected 2", n);
      end
   endtask

   task automatic test_mult_mflo();
      int n;
      flush();
      IR_D = enc_r(5'd1, 5'd2, 5'd0, 6'h18);
      tick();
      IR_D = enc_r(5'd0, 5'd0, 5'd3, 6'h12);
      @(negedge clk);
      checks++;
      if ({md_start_E, md_op_E} !== 3'b100) begin
         errors++;
         $display("FAIL mult_start got %b expected 100", {md_start_E, md_op_E});
      end
      n = 0;
      while (stall === 1'b1 && n < 20) begin
         n++;
         tick();
         @(negedge clk);
      end
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL mflo_stalls got %0d expected 6", n);
      end
      tick();
      IR_D = 32'h0;
      @(negedge clk);
      checks++;
      if ({hilo_sel_E, MemtoReg_E, A3_E} !== {1'b1, 3'd3, 5'd3}) begin
         errors++;
         $display("FAIL mflo_in_e got hilo=%b m2r=%0d A3=%0d expected 1/3/3", hilo_sel_E, MemtoReg_E, A3_E);
      end
   endtask

   task automatic test_divu();
      int n;
      flush();
      IR_D = enc_r(5'd1, 5'd2, 5'd0, 6'h1b);
      tick();
      IR_D = enc_r(5'd2, 5'd3, 5'd1, 6'h21);
      @(negedge clk);
      checks++;
      if ({stall, md_start_E, md_op_E, md_busy} !== 5'b01110) begin
         errors++;
         $display("FAIL divu_start got %b expected 01110", {stall, md_start_E, md_op_E, md_busy});
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         IR_D = 32'h0;
         @(negedge clk);
         if (i == 0) begin
            checks++;
            if (A3_E !== 5'd1) begin
               errors++;
               $display("FAIL divu_addu_in_e got %0d expected 1", A3_E);
            end
         end
         if (md_busy === 1'b1) n++;
      end
      checks++;
      if (n !== 10) begin
         errors++;
         $display("FAIL divu_busy_cycles got %0d expected 10", n);
      end
   endtask

   task automatic test_jal_jalr();
      flush();
      IR_D = {6'h03, 26'h100};
      @(negedge clk);
      checks++;
      if ({stall, PC_sel_D} !== {1'b0, 3'd3}) begin
         errors++;
         $display("FAIL jal_pcsel got %b expected 0011", {stall, PC_sel_D});
      end
      tick();
      IR_D = enc_r(5'd31, 5'd0, 5'd4, 6'h09);
      @(negedge clk);
      checks++;
      if ({stall, PC_sel_D, A3_E, MemtoReg_E} !== {1'b0, 3'd2, 5'd31, 3'd2}) begin
         errors++;
         $display("FAIL jalr_after_jal got stall=%b pcsel=%0d A3_E=%0d m2r=%0d expected 0/2/31/2", stall, PC_sel_D, A3_E, MemtoReg_E);
      end
      tick();
      IR_D = 32'h0;
      @(negedge clk);
      checks++;
      if ({A3_E, MemtoReg_E, A3_M} !== {5'd4, 3'd2, 5'd31}) begin
         errors++;
         $display("FAIL jalr_in_e got A3_E=%0d m2r=%0d A3_M=%0d expected 4/2/31", A3_E, MemtoReg_E, A3_M);
      end
   endtask

   task automatic test_random();
      logic [31:0] ie, im, iw;
      logic es, busy, hold;
      int edges, start, n;
      reset = 1'b1;
      IR_D  = 32'h0;
      tick();
      reset = 1'b0;
      ie = 32'h0;
      im = 32'h0;
      iw = 32'h0;
      edges = 0;
      start = 0;
      n = 0;
      hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!hold) IR_D = rand_ir();
         @(negedge clk);
         busy = n > 0 && edges >= start && edges < start + n;
         es = exp_stall(IR_D, ie, im, busy);
         checks++;
         if ({stall, PC_sel_D, ExtOp_D} !== {es, f_pcsel(kind(IR_D)), f_ext(kind(IR_D))}) begin
            errors++;
            $display("FAIL rand_comb cyc=%0d ir=%h got %b expected %b", i, IR_D, {stall, PC_sel_D, ExtOp_D}, {es, f_pcsel(kind(IR_D)), f_ext(kind(IR_D))});
         end
         checks++;
         if (regs_v !== exp_regs(ie, im, iw, busy)) begin
            errors++;
            $display("FAIL rand_regs cyc=%0d got %h expected %h", i, regs_v, exp_regs(ie, im, iw, busy));
         end
         hold = es;
         if (is_md(kind(ie))) begin
            start = edges + 1;
            n = kind(ie) inside {K_DIV, K_DIVU} ? 10 : 5;
         end
         edges++;
         iw = im;
         im = ie;
         ie = es ? 32'h0 : IR_D;
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      IR_D  = 32'h0;
      test_reset();
      test_load_use();
      test_branch();
      test_mult_mflo();
      test_divu();
      test_jal_jalr();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle combinational decoder of the five-stage MIPS core.
- Decodes IR_D in the D stage and carries the control bundle through E/M/W registers.
- Computes the Tuse/Tnew load-use and branch stall, and inserts E-stage bubbles.
- Adds a parametrised multi-cycle mult/div busy counter with HI/LO access interlock.

Parameters:
MULT_CYCLES, 5, busy cycles after mult/multu starts in E (1..2^CNT_W-1)
DIV_CYCLES, 10, busy cycles after div/divu starts in E (1..2^CNT_W-1)
CNT_W, 4, busy counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
IR_D  in  32  instruction in D stage
stall  out  1  combinational; freeze PC and D register, bubble E
PC_sel_D  out  3  0 PC+4, 1 beq target, 2 jr/jalr, 3 j/jal
ExtOp_D  out  3  0 sign, 1 zero, 2 lui
ALUCtrl_E  out  3  0 add, 1 sub, 2 or
ALUB_sel_E  out  1  0 rt, 1 ext
md_op_E  out  2  0 mult, 1 multu, 2 div, 3 divu
md_start_E  out  1  mult/div in E (registered bundle bit)
mt_hi_E  out  1  mthi in E
mt_lo_E  out  1  mtlo in E
hilo_sel_E  out  1  0 HI, 1 LO (mf source)
md_busy  out  1  counter non-zero
A3_E  out  5  destination register in E; 0 if no write
A3_M  out  5  destination register in M
A3_W  out  5  destination register in W
MemWrite_M  out  1  sw in M
MemtoReg_E  out  3  0 ALU, 1 DM, 2 PC+8, 3 HI/LO
MemtoReg_M  out  3  as above
MemtoReg_W  out  3  as above

Behaviour:
- Supported: addu subu ori lui lw sw beq j jal jr jalr mult multu div divu mfhi mflo mthi mtlo; anything else, including 0x00000000, decodes to the all-zero nop bundle with A3=0.
- A3 selection: rt for ori/lui/lw, rd for R-type writes, 31 for jal. jalr writes rd. jr, sw, beq, j, mult/div, mt write nothing, so A3=0.
- Decoded encodings and values match the single-cycle controller; MemtoReg adds value 3 for mfhi/mflo.
- Tuse(rs): 0 for beq, jr, jalr; 1 otherwise when rs is read.
- Tuse(rt): 0 for beq; 1 for R-type ALU and mult/div; 2 for sw.
- Tnew in E: lw 2; ALU, lui, ori, mf 1; jal/jalr 0.
- Tnew in M: lw 1; all else 0.
- Data stall: for rs and rt independently, if src≠0, src==A3_X and Tnew_X>Tuse, where X is E (Tnew_E) or M (Tnew_M−0).
- MD stall: IR_D is mult/div/mf/mt and (md_start_E or md_busy).
- stall = data stall OR MD stall.
- Each posedge, normal: E<=decode(IR_D), M<=E, W<=M.
- Each posedge, stall: E<=nop bundle; M<=E, W<=M still advance.
- Counter: if md_start_E, cnt<=MULT_CYCLES or DIV_CYCLES by md_op_E; else if cnt≠0, cnt<=cnt−1. md_busy is high for exactly N cycles after the start cycle.
- Reset: all E/M/W bundles become nop (every registered output 0) and cnt<=0 on the next edge. This overrides stall and any in-flight divide (md_busy 0 after that edge).
- stall, PC_sel_D and ExtOp_D are combinational from IR_D and the registered state; no registered output changes without a clk edge.

Test Plan:
- reset held 2 cycles with a div in E -> all registered outputs 0, md_busy 0, A3_E/M/W=0 after release.
- lw $8,0($0) in D then addu $9,$8,$8 -> 1 stall cycle with addu in D; A3_E=0 bubble; addu enters E next cycle with A3_E=9.
- ori $5,$0,1 then beq $5,$0 -> 1 stall cycle (Tnew_E 1 > Tuse 0); lw $5 then beq $5 -> 2 stall cycles.
- mult then mflo with defaults -> mult in E: md_start_E=1; mflo stalls for 1+5=6 cycles, then enters E with hilo_sel_E=1, MemtoReg_E=3.
- divu then addu $1,$2,$3 -> no stall; md_busy high 10 cycles; md_op_E=3 during the start cycle.
- jal then jalr $4,$31 -> A3_E=31, MemtoReg_E=2, PC_sel_D=3 for jal; jalr: no stall (Tnew_E 0), PC_sel_D=2, later A3_E=4.
